// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Latches the winner's byte, holds tx_en until tx_done, acks, then enforces an idle gap.
module uart_tx_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IDLE_GAP    = 2,
  parameter int unsigned WDOG_CYCLES = 20000
) (
  input  logic                   clk_100MHz,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic                   timeout,
  output logic                   tx_en,
  output logic [DATA_W-1:0]      tx_din,
  input  logic                   tx_done
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WdW  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  localparam logic [PtrW-1:0] PtrLast = PtrW'(NREQ - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(WDOG_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [WdW-1:0]    wdog_q, wdog_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              seen_low_q, seen_low_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] tx_din_q, tx_din_d;

  logic              found;
  logic [PtrW-1:0]   win;
  logic [PtrW-1:0]   cand;
  logic [DATA_W-1:0] win_data;

  // Scan ptr, ptr+1, ... modulo NREQ; first pending request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = ptr_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = PtrW'((int'(ptr_q) + i) % int'(NREQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win == PtrW'(i)) begin
        win_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wdog_d     = wdog_q;
    gap_d      = gap_q;
    seen_low_d = seen_low_q;
    grant_d    = grant_q;
    ack_d      = '0;
    timeout_d  = 1'b0;
    tx_en_d    = tx_en_q;
    tx_din_d   = tx_din_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StSend;
          grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
          tx_din_d   = win_data;
          tx_en_d    = 1'b1;
          ptr_d      = (win == PtrLast) ? '0 : win + 1'b1;
          wdog_d     = '0;
          seen_low_d = 1'b0;
        end
      end
      StSend: begin
        // A tx_done left high from the previous frame must not complete this one.
        if (!tx_done) begin
          seen_low_d = 1'b1;
        end
        if (tx_done && seen_low_q) begin
          state_d = StGap;
          tx_en_d = 1'b0;
          ack_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
        end else if (WDOG_CYCLES != 0 && wdog_q == WdLast) begin
          state_d   = StGap;
          tx_en_d   = 1'b0;
          timeout_d = 1'b1;
          grant_d   = '0;
          gap_d     = '0;
        end else if (WDOG_CYCLES != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          if (!tx_done) begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      wdog_q     <= '0;
      gap_q      <= '0;
      seen_low_q <= 1'b0;
      grant_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_din_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      seen_low_q <= seen_low_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      tx_en_q    <= tx_en_d;
      tx_din_q   <= tx_din_d;
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign tx_en   = tx_en_q;
  assign tx_din  = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table of request patterns with expected RR order,
// a transmitter model, a frame scoreboard and hand sequences for the multi-cycle cases.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAP  = 2;
  localparam int WDOG = 100;

  logic                 clk_100MHz;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic                 timeout;
  logic                 tx_en;
  logic [DW-1:0]        tx_din;
  logic                 tx_done;

  uart_tx_arbiter #(
    .NREQ       (NREQ),
    .DATA_W     (DW),
    .IDLE_GAP   (GAP),
    .WDOG_CYCLES(WDOG)
  ) u_dut (
    .clk_100MHz(clk_100MHz),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .ack       (ack),
    .busy      (busy),
    .timeout   (timeout),
    .tx_en     (tx_en),
    .tx_din    (tx_din),
    .tx_done   (tx_done)
  );

  typedef struct {
    int          idx;
    logic [7:0]  byte_v;
    logic        exp_ack;
  } frm_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          n;
    logic [15:0] ord;  // expected winner of frame k in nibble k
  } vec_t;

  frm_t sb[$];
  frm_t cur;
  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, n_ack = 0, n_to = 0, en_run = 0, last_gap = 0;
  int ack_cyc = 0, end_cyc = 0, done_fall_cyc = 0;
  bit cur_active = 0, have_end = 0, prev_en = 0, prev_done = 0;

  int tx_len = 4, done_hold = 0, en_cnt = 0, hold_cnt = 0;
  bit model_on = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || cur_active || busy) && n < bound) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("drain_in_time", n < bound, 1);
  endtask

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // Transmitter model: raises tx_done tx_len cycles into a frame, drops it done_hold
  // cycles after tx_en falls.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (tx_en) begin
        en_cnt++;
        hold_cnt = 0;
        if (model_on && en_cnt >= tx_len) tx_done = 1'b1;
      end else begin
        en_cnt = 0;
        if (model_on && tx_done) begin
          if (hold_cnt >= done_hold) tx_done = 1'b0;
          else hold_cnt++;
        end
      end
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    bit keep;
    forever begin
      @(negedge clk_100MHz);
      cyc++;
      if (!rst) begin
        prev_en    = 0;
        prev_done  = tx_done;
        cur_active = 0;
        have_end   = 0;
      end else begin
        check("invariants", {$onehot0(grant), $onehot0(ack), !(|ack && timeout),
                             (tx_en || grant == '0)}, 4'hF);
        if (prev_done && !tx_done) done_fall_cyc = cyc;
        if (tx_en && !prev_en) begin
          en_run = 1;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: grant %b tx_din %h, none expected", grant, tx_din);
          end else begin
            cur = sb.pop_front();
            check("grant", grant, 64'd1 << cur.idx);
            check("tx_din", tx_din, cur.byte_v);
            cur_active = 1;
          end
          if (have_end) begin
            last_gap = cyc - end_cyc;
            check("idle_gap", last_gap >= GAP + 1, 1);
            check("rise_after_done_low", (done_fall_cyc >= ack_cyc) && (cyc > done_fall_cyc), 1);
          end
        end else if (tx_en) begin
          en_run++;
          if (cur_active) check("frame_stable", {grant, tx_din}, {4'b1 << cur.idx, cur.byte_v});
        end
        if (|ack) begin
          n_ack++;
          check("ack", ack, (cur_active && cur.exp_ack) ? (64'd1 << cur.idx) : 64'd0);
          ack_cyc    = cyc;
          end_cyc    = cyc;
          have_end   = 1;
          cur_active = 0;
          for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
              keep = 0;
              foreach (sb[j]) if (sb[j].idx == i) keep = 1;
              if (!keep) req[i] = 1'b0;
            end
          end
        end
        if (timeout) begin
          n_to++;
          check("timeout_expected", cur_active && !cur.exp_ack, 1);
          check("wdog_len", en_run, WDOG);
          end_cyc    = cyc;
          have_end   = 1;
          cur_active = 0;
        end
        prev_en   = tx_en;
        prev_done = tx_done;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int n;
    int idx;
    int acks0;
    logic [15:0] o;

    vecs[0] = '{req: 4'b1111, data: 32'h4433_2211, n: 4, ord: 16'h3210};
    vecs[1] = '{req: 4'b0101, data: 32'h0066_0055, n: 2, ord: 16'h0020};
    vecs[2] = '{req: 4'b0011, data: 32'h0000_BBAA, n: 4, ord: 16'h1010};
    vecs[3] = '{req: 4'b0001, data: 32'h0000_00A5, n: 1, ord: 16'h0000};
    vecs[4] = '{req: 4'b1010, data: 32'h9900_7700, n: 2, ord: 16'h0031};
    vecs[5] = '{req: 4'b1100, data: 32'hE1C3_0000, n: 2, ord: 16'h0032};

    rst  = 1'b0;
    req  = '0;
    data = '0;
    repeat (3) @(negedge clk_100MHz);
    check("reset_outputs", {grant, ack, busy, timeout, tx_en, tx_din}, 0);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      @(negedge clk_100MHz);
      data = vecs[v].data;
      o    = vecs[v].ord;
      for (int k = 0; k < vecs[v].n; k++) begin
        idx = int'(o[k*4 +: 4]);
        sb.push_back('{idx, data[idx*8 +: 8], 1'b1});
      end
      req = vecs[v].req;
      wait_drain(1000);
      check("req_served", req, 0);
    end

    // Watchdog: transmitter silent, requester 1 times out, then 2 and 1 are served.
    @(negedge clk_100MHz);
    model_on = 0;
    data = 32'h00B2_B100;
    sb.push_back('{1, 8'hB1, 1'b0});
    sb.push_back('{2, 8'hB2, 1'b1});
    sb.push_back('{1, 8'hB1, 1'b1});
    acks0 = n_ack;
    req = 4'b0110;
    n = 0;
    while (n_to == 0 && n < 300) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("timeout_seen", n_to, 1);
    check("no_ack_on_timeout", n_ack - acks0, 0);
    model_on = 1;
    wait_drain(500);
    check("acks_after_timeout", n_ack - acks0, 2);

    // Asynchronous reset in the middle of requester 1's frame.
    @(negedge clk_100MHz);
    tx_len = 30;
    data = 32'h00D2_C100;
    sb.push_back('{1, 8'hC1, 1'b0});
    req = 4'b0010;
    n = 0;
    while (!cur_active && n < 50) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("rst_frame_started", cur_active, 1);
    repeat (5) @(negedge clk_100MHz);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {grant, ack, busy, timeout, tx_en, tx_din}, 0);
    @(negedge clk_100MHz);
    tx_len = 4;
    sb.push_back('{1, 8'hC1, 1'b1});
    sb.push_back('{2, 8'hD2, 1'b1});
    req = 4'b0110;
    @(negedge clk_100MHz);
    rst = 1'b1;
    wait_drain(500);

    // tx_done held high well past the frame: next frame waits for it to fall.
    @(negedge clk_100MHz);
    done_hold = 10;
    data = 32'h00F2_00F0;
    sb.push_back('{0, 8'hF0, 1'b1});
    sb.push_back('{2, 8'hF2, 1'b1});
    req = 4'b0101;
    wait_drain(500);
    check("gap_waits_done", last_gap > 10, 1);
    done_hold = 0;

    // Stale tx_done high at SEND entry must not complete the frame.
    @(negedge clk_100MHz);
    model_on = 0;
    tx_done = 1'b1;
    data = 32'h5A00_0000;
    sb.push_back('{3, 8'h5A, 1'b1});
    req = 4'b1000;
    @(negedge clk_100MHz);
    check("grant_latency", {tx_en, grant, tx_din}, {1'b1, 4'b1000, 8'h5A});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_100MHz);
      check("stale_done_no_ack", {tx_en, ack}, {1'b1, 4'b0000});
    end
    tx_done = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    acks0 = n_ack;
    tx_done = 1'b1;
    n = 0;
    while (n_ack == acks0 && n < 20) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("fresh_done_acks", n_ack - acks0, 1);
    tx_done = 1'b0;
    model_on = 1;
    wait_drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
